// File: rtl/ttl_freq_gen_pkg.sv
// Shared definitions for the TTL frequency generator: FSM states, BCD digit
// constants and the default system clock rate (also used by the meter's
// gate-time divider).
package ttl_freq_gen_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX        = 9;
  localparam int CLK_HZ_DEFAULT = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    CHECK,
    APPLY,
    REJECT
  } state_t;

endpackage

// File: rtl/ttl_freq_gen_if.sv
// Setpoint load channel: a BCD frequency word with a valid/ready handshake.
interface ttl_freq_gen_if
  import ttl_freq_gen_pkg::*;
#(
  parameter int DIGITS = 6
);

  logic                    set_valid;
  logic                    set_ready;
  logic [BCD_W*DIGITS-1:0] set_bcd;

  modport master (output set_valid, output set_bcd, input set_ready);
  modport slave  (input set_valid, input set_bcd, output set_ready);

endinterface

// File: rtl/ttl_freq_gen_bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per step, most significant
// digit first, bin = bin*10 + digit.  Flags a non-decimal digit on the step
// that reaches it and marks the step that consumes the last digit.
module ttl_freq_gen_bcd_to_bin_seq
  import ttl_freq_gen_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int FREQ_W = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    step,
  input  logic [BCD_W*DIGITS-1:0] bcd,
  output logic [FREQ_W-1:0]       bin,
  output logic                    done,
  output logic                    err
);

  localparam int K_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [K_W-1:0] K_MSD = K_W'(DIGITS - 1);

  logic [BCD_W*DIGITS-1:0] bcd_q;
  logic [K_W-1:0]          k;
  logic [FREQ_W-1:0]       bin_q;
  logic [BCD_W-1:0]        digit;

  // The digit under conversion always sits at the top of the shifted word.
  assign digit = bcd_q[BCD_W*DIGITS-1 -: BCD_W];
  assign err   = step && (digit > BCD_W'(BCD_MAX));
  assign done  = step && (k == '0);
  assign bin   = bin_q;

  // Capture the setpoint on start, then fold in one digit per step.
  always_ff @(posedge clock) begin
    // NOTE: the captured word is cleared on reset too, so an aborted
    // conversion can never leak a partial value into a later one.
    if (reset) begin
      bcd_q <= '0;
      k     <= '0;
      bin_q <= '0;
    end else if (start) begin
      bcd_q <= bcd;
      k     <= K_MSD;
      bin_q <= '0;
    end else if (step && !err) begin
      bin_q <= (bin_q << 3) + (bin_q << 1) + FREQ_W'(digit);
      bcd_q <= bcd_q << BCD_W;
      if (k != '0) k <= k - K_W'(1);
    end
  end

endmodule

// File: rtl/ttl_freq_gen.sv
// Programmable TTL square-wave source.  A BCD setpoint in Hz is converted to
// binary, range-checked, and applied to a fractional accumulator that toggles
// ttl_out 2*freq_bin times per CLK_HZ clocks, giving an exact mean frequency.
module ttl_freq_gen
  import ttl_freq_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int DIGITS = 6,
  parameter int FREQ_W = 20,
  parameter int ACC_W  = 27
) (
  input  logic               clock,
  input  logic               reset,
  ttl_freq_gen_if.slave      set_if,
  input  logic               enable,
  output logic               ttl_out,
  output logic [FREQ_W-1:0]  freq_bin,
  output logic               busy,
  output logic               range_err
);

  localparam logic [ACC_W-1:0] CLK_MOD = ACC_W'(CLK_HZ);

  state_t            state, state_nxt;
  logic              accept;
  logic [FREQ_W-1:0] bin;
  logic              conv_done, conv_err;
  logic [ACC_W-1:0]  bin2;
  logic [ACC_W-1:0]  inc, acc, sum;

  assign set_if.set_ready = (state == IDLE) && !reset;
  assign accept           = set_if.set_valid && set_if.set_ready;
  assign busy             = (state == CONV);
  assign bin2             = ACC_W'(bin) << 1;
  assign sum              = acc + inc;

  ttl_freq_gen_bcd_to_bin_seq #(
    .DIGITS (DIGITS),
    .FREQ_W (FREQ_W)
  ) u_conv (
    .clock (clock),
    .reset (reset),
    .start (accept),
    .step  (state == CONV),
    .bcd   (set_if.set_bcd),
    .bin   (bin),
    .done  (conv_done),
    .err   (conv_err)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: load, convert, range check, then apply or reject.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned and infers a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (conv_err) state_nxt = REJECT;
               else if (conv_done) state_nxt = CHECK;
      CHECK:   state_nxt = (bin2 > CLK_MOD) ? REJECT : APPLY;
      APPLY:   state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Active setpoint and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq_bin  <= '0;
      inc       <= '0;
      range_err <= 1'b0;
    end else if (state == APPLY) begin
      freq_bin  <= bin;
      inc       <= bin2;
      range_err <= 1'b0;
    end else if (state == REJECT) begin
      range_err <= 1'b1;
    end
  end

  // Fractional accumulator: phase restarts on apply, freezes while disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      ttl_out <= 1'b0;
    end else if (state == APPLY) begin
      acc     <= '0;
      ttl_out <= 1'b0;
    end else if (!enable || inc == '0) begin
      ttl_out <= 1'b0;
    end else if (sum >= CLK_MOD) begin
      acc     <= sum - CLK_MOD;
      ttl_out <= ~ttl_out;
    end else begin
      acc     <= sum;
    end
  end

endmodule

// File: tb/tb_ttl_freq_gen.sv
// Directed bench for ttl_freq_gen with a 1 kHz clock modulus so waveform
// periods stay short.  Inputs change and outputs are sampled on the falling
// clock edge.
module tb_ttl_freq_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        ttl_out;
  logic [19:0] freq_bin;
  logic        busy;
  logic        range_err;

  int vectors    = 0;
  int miscompares = 0;

  ttl_freq_gen_if #(.DIGITS(6)) set_if ();

  ttl_freq_gen #(
    .CLK_HZ (1000),
    .DIGITS (6),
    .FREQ_W (20),
    .ACC_W  (27)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .set_if    (set_if.slave),
    .enable    (enable),
    .ttl_out   (ttl_out),
    .freq_bin  (freq_bin),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a setpoint for one accepting edge, then count cycles with
  // set_ready low until it returns (bounded).
  task automatic load(input logic [23:0] bcd, output int low_cycles);
    @(negedge clock);
    set_if.set_bcd   = bcd;
    set_if.set_valid = 1'b1;
    @(negedge clock);
    set_if.set_valid = 1'b0;
    low_cycles = 0;
    while (!set_if.set_ready && low_cycles < 50) begin
      low_cycles++;
      @(negedge clock);
    end
  endtask

  // Observe ttl_out for n cycles; half-periods exclude the leading partial one.
  task automatic measure(input int n, output int rises, output int min_h, output int max_h);
    logic prev;
    int   last_edge;
    prev      = ttl_out;
    last_edge = -1;
    rises     = 0;
    min_h     = 1_000_000;
    max_h     = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (ttl_out !== prev) begin
        if (ttl_out === 1'b1) rises++;
        if (last_edge >= 0) begin
          if (i - last_edge < min_h) min_h = i - last_edge;
          if (i - last_edge > max_h) max_h = i - last_edge;
        end
        last_edge = i;
        prev      = ttl_out;
      end
    end
  endtask

  initial begin
    int low, rises, min_h, max_h, cnt, bad;

    reset            = 1'b1;
    enable           = 1'b1;
    set_if.set_valid = 1'b0;
    set_if.set_bcd   = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state.
    check("rst_ttl_out", ttl_out, 0);
    check("rst_freq_bin", freq_bin, 0);
    check("rst_busy", busy, 0);
    check("rst_range_err", range_err, 0);
    check("rst_set_ready", set_if.set_ready, 1);

    // 100 Hz: half-period exactly 5 clocks.
    @(negedge clock);
    set_if.set_bcd   = 24'h000100;
    set_if.set_valid = 1'b1;
    @(negedge clock);
    set_if.set_valid = 1'b0;
    check("conv_busy", busy, 1);
    low = 1;
    while (!set_if.set_ready && low < 50) begin
      @(negedge clock);
      if (!set_if.set_ready) low++;
    end
    check("f100_ready_low", low, 8);
    check("f100_freq_bin", freq_bin, 100);
    check("f100_range_err", range_err, 0);
    measure(100, rises, min_h, max_h);
    check("f100_rises", rises, 10);
    check("f100_min_half", min_h, 5);
    check("f100_max_half", max_h, 5);

    // Freeze mid-phase (acc=400), hold 37 cycles, resume 3 clocks later.
    cnt = 0;
    begin
      logic prev;
      prev = ttl_out;
      do begin
        @(negedge clock);
        cnt++;
      end while (ttl_out === prev && cnt < 20);
    end
    check("en_find_edge", (cnt < 20), 1);
    repeat (2) @(negedge clock);
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clock);
      if (ttl_out !== 1'b0) bad++;
    end
    check("en_off_low_cycles_high", bad, 0);
    enable = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (ttl_out !== 1'b1 && cnt < 20);
    check("en_resume_first_edge", cnt, 3);
    measure(30, rises, min_h, max_h);
    check("en_resume_min_half", min_h, 5);
    check("en_resume_max_half", max_h, 5);

    // Bad digit at k=1: early reject, setpoint and waveform untouched.
    load(24'h0012A4, low);
    check("bad_digit_ready_low", low, 6);
    check("bad_digit_range_err", range_err, 1);
    check("bad_digit_freq_bin", freq_bin, 100);
    measure(40, rises, min_h, max_h);
    check("bad_digit_min_half", min_h, 5);
    check("bad_digit_max_half", max_h, 5);

    load(24'h000050, low);
    check("f50_range_err", range_err, 0);
    check("f50_freq_bin", freq_bin, 50);

    // Range limit: 2*501 > 1000 rejected, 500 accepted.
    load(24'h000501, low);
    check("f501_ready_low", low, 8);
    check("f501_range_err", range_err, 1);
    check("f501_freq_bin", freq_bin, 50);
    load(24'h000500, low);
    check("f500_range_err", range_err, 0);
    check("f500_freq_bin", freq_bin, 500);
    measure(20, rises, min_h, max_h);
    check("f500_min_half", min_h, 1);
    check("f500_max_half", max_h, 1);

    // 3 Hz: 9 rising edges in 3000 clocks, phases 166 or 167.
    load(24'h000003, low);
    check("f3_freq_bin", freq_bin, 3);
    measure(3000, rises, min_h, max_h);
    check("f3_rises", rises, 9);
    check("f3_min_half", min_h, 166);
    check("f3_max_half", max_h, 167);

    // Valid held with changing data: only the first word is used.
    @(negedge clock);
    set_if.set_bcd   = 24'h000007;
    set_if.set_valid = 1'b1;
    @(negedge clock);
    cnt = 0;
    while (!set_if.set_ready && cnt < 50) begin
      cnt++;
      set_if.set_bcd = 24'h000011 + 24'(cnt);
      @(negedge clock);
    end
    set_if.set_valid = 1'b0;
    check("hold_valid_ready_low", cnt, 8);
    @(negedge clock);
    check("hold_valid_freq_bin", freq_bin, 7);
    check("hold_valid_range_err", range_err, 0);

    // Reset during the third conversion cycle.
    @(negedge clock);
    set_if.set_bcd   = 24'h000200;
    set_if.set_valid = 1'b1;
    @(negedge clock);
    set_if.set_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready_in_reset", set_if.set_ready, 0);
    @(negedge clock);
    check("mid_rst_ttl_out", ttl_out, 0);
    check("mid_rst_freq_bin", freq_bin, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_range_err", range_err, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", set_if.set_ready, 1);
    repeat (10) @(negedge clock);
    check("mid_rst_no_apply", freq_bin, 0);

    // Zero setpoint is a legal load that silences the output.
    load(24'h000100, low);
    check("pre_zero_freq_bin", freq_bin, 100);
    load(24'h000000, low);
    check("zero_freq_bin", freq_bin, 0);
    check("zero_range_err", range_err, 0);
    measure(50, rises, min_h, max_h);
    check("zero_rises", rises, 0);
    check("zero_ttl_out", ttl_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ttl_freq_gen.md
Name: ttl_freq_gen

Overview:
- Programmable TTL square-wave source. It is the transmitter end of the frequency meter's measured input: ttl_out drives the meter's clock_text pin for self-test and calibration.
- A 6-digit BCD frequency setpoint in Hz arrives over a valid/ready load interface. The same digit format is what the meter counter produces.
- The setpoint is converted to binary over several cycles. A fractional accumulator then generates a 50% duty square wave whose average frequency is exact.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz; also the accumulator modulus.
- DIGITS, 6: number of BCD digits in set_bcd.
- FREQ_W, 20: binary setpoint width; must hold 10^DIGITS-1.
- ACC_W, 27: accumulator width; must hold CLK_HZ + 2*(10^DIGITS-1).

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- set_valid  in  1  setpoint load request
- set_ready  out  1  high when a new setpoint can be accepted
- set_bcd  in  4*DIGITS  BCD setpoint in Hz; digit DIGITS-1 is at the MSBs
- enable  in  1  1 = generate, 0 = freeze phase and hold ttl_out low
- ttl_out  out  1  generated square wave
- freq_bin  out  FREQ_W  active binary setpoint in Hz
- busy  out  1  conversion in progress
- range_err  out  1  sticky; last load rejected; cleared by the next accepted valid load

Behaviour:
- Reset values: ttl_out=0, freq_bin=0, busy=0, range_err=0, set_ready=1, acc=0, inc=0, state IDLE. Reset mid-conversion aborts the conversion; the partial result is discarded.
- Handshake:
  - Load accepted on a cycle with set_valid && set_ready; set_bcd is captured that cycle.
  - set_ready = (state==IDLE) && !reset.
  - set_valid while not ready is ignored; no queueing.
- FSM states:
  - IDLE: on an accepted load, go to CONV and set digit index k=DIGITS-1, bin=0.
  - CONV: one digit per cycle, MSD first: bin <= bin*10 + digit[k], computed as (bin<<3)+(bin<<1)+digit.
    - Any digit >9 goes directly to REJECT.
    - After the k=0 digit, go to CHECK.
    - busy=1 throughout CONV.
  - CHECK: if 2*bin > CLK_HZ go to REJECT, else go to APPLY.
  - APPLY (one cycle): freq_bin<=bin, inc<=2*bin, acc<=0, ttl_out<=0, range_err<=0; return to IDLE.
  - REJECT (one cycle): range_err<=1; freq_bin, inc and the running waveform are unchanged; return to IDLE.
- Latency: acceptance at cycle 0, CONV at cycles 1..DIGITS, CHECK at DIGITS+1, APPLY/REJECT at DIGITS+2, set_ready high again at DIGITS+3.
- Generator, evaluated every cycle outside APPLY:
  - If !enable or inc==0: acc holds and ttl_out<=0.
  - Otherwise sum = acc+inc:
    - if sum >= CLK_HZ: acc <= sum-CLK_HZ and ttl_out toggles;
    - else acc <= sum.
  - The toggle rate is 2*freq_bin per CLK_HZ clocks, so the average frequency equals freq_bin exactly.
  - For frequencies not dividing CLK_HZ/2, half-periods vary by at most 1 clock.
- Deasserting enable freezes acc. Reasserting it resumes from the frozen phase with ttl_out starting at 0.
- The old waveform keeps running during CONV/CHECK; it switches only at APPLY.
- freq_bin=0 or setpoint 000000: ttl_out held at constant 0; this is an accepted load, not an error.
- Maximum setpoint 999999 with the default CLK_HZ is legal.
- Widths: comparisons and subtraction use ACC_W bits with no truncation; 2*bin is computed at ACC_W bits.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, CONV, CHECK, APPLY, REJECT);
  - BCD_W=4, BCD_MAX=9;
  - the default CLK_HZ, reused by the meter's gate-time divider.
- One sub-module is natural: bcd_to_bin_seq, covering the CONV datapath and digit sequencing with start/done/err. The parent keeps the handshake, CHECK/APPLY and the accumulator.

Test Plan:
- CLK_HZ=1000; load 000100; then count clocks between ttl_out edges → every half-period is exactly 5 clocks, period 10; freq_bin=100; set_ready low for exactly 8 cycles after acceptance.
- CLK_HZ=1000; load 000003 → inc=6; over 3000 clocks ttl_out produces exactly 9 rising edges; high/low phases are 166 or 167 clocks.
- Load 0012A4, which contains digit 0xA → range_err=1 one cycle after the bad digit is reached; freq_bin and the waveform are unchanged. A following valid load 000050 clears range_err.
- CLK_HZ=1000; load 000501 (2*501 > 1000) → REJECT, range_err=1. Load 000500 → accepted; ttl_out toggles every clock.
- Assert set_valid continuously with a changing set_bcd during CONV → only the first value is applied. Assert reset at CONV cycle 3 → all outputs return to their reset values next cycle and set_ready=1.
- Running at 100 Hz: drop enable for 37 cycles → ttl_out=0 and acc is frozen; on re-enable, edge spacing continues from the saved acc. Load 000000 → ttl_out stays 0 and no error is flagged.
